sc_io_bus: RTL and testbench

Parametrised memory-mapped I/O block for the single-cycle CPU. It generalises the fixed switch input ports and seven-segment output ports to N_IN debounced input channels and N_OUT 32-bit output registers. Each output register has its own sequential binary-to-BCD converter that drives DIGITS active-low seven-segment digits. It sits between the CPU data-memory I/O window and the board switches and HEX displays.

---
 rtl/sc_io_bus_if.sv | 11 +
 rtl/sc_io_bus.sv | 182 ++++++++++++++++++
 tb/tb_sc_io_bus.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_io_bus_if.sv
// CPU-side I/O window bus for sc_io_bus: address, write strobe/data and
// combinational read data.
interface sc_io_bus_if;
  logic [7:0]  io_addr;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (output io_addr, io_we, io_wdata, input io_rdata);
  modport slave  (input io_addr, io_we, io_wdata, output io_rdata);
endinterface

// File: rtl/sc_io_bus.sv
// Memory-mapped I/O: debounced switch inputs, 32-bit output registers, and a
// per-port sequential double-dabble converter feeding active-low 7-seg digits.
//
// Converter FSM (one per output port)
//   state | meaning
//   IDLE  | digits hold last result, busy low
//   SHIFT | one add-3/shift step per edge until CONV_W bits consumed
//   LOAD  | latch BCD into segment registers (or dashes on overflow)
module sc_io_bus #(
  parameter int N_IN   = 2,
  parameter int IN_W   = 5,
  parameter int N_OUT  = 3,
  parameter int DIGITS = 2,
  parameter int CONV_W = 7,
  parameter int DBNC   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  sc_io_bus_if.slave                 bus,
  input  logic [N_IN*IN_W-1:0]       sw,
  output logic [N_OUT*32-1:0]        out_port,
  output logic [N_OUT*DIGITS*7-1:0]  hex,
  output logic [N_OUT-1:0]           busy
);

  localparam int NIB    = (CONV_W + 2) / 3;
  localparam int BCD_W  = 4 * NIB;
  localparam int PAD_W  = 4 * ((NIB > DIGITS) ? NIB : DIGITS);
  localparam int STEP_W = $clog2(CONV_W + 1);
  localparam int CNT_W  = (DBNC > 1) ? $clog2(DBNC) : 1;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_e;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  logic [5:0]            word;
  logic [N_IN*IN_W-1:0]  stable_all;
  logic                  unused_lane;

  assign word        = bus.io_addr[7:2];
  assign unused_lane = ^bus.io_addr[1:0];  // byte-lane bits are don't-care

  // s2 doubles as the previous sample of s1, so a held change is accepted
  // DBNC+1 edges after it first lands in s1.
  for (genvar k = 0; k < N_IN; k++) begin : g_in
    logic [IN_W-1:0]  s1, s2, stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1     <= '0;
        s2     <= '0;
        stable <= '0;
        cnt    <= '0;
      end else begin
        s1 <= sw[k*IN_W +: IN_W];
        s2 <= s1;
        if (s1 != s2) begin
          cnt <= '0;
        end else if (s1 != stable) begin
          if (cnt == CNT_W'(DBNC - 1)) begin
            stable <= s1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign stable_all[k*IN_W +: IN_W] = stable;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    logic                  wr;
    conv_state_e           state, state_n;
    logic [CONV_W-1:0]     shift, shift_n;
    logic [BCD_W-1:0]      bcd, bcd_n, adj;
    logic [PAD_W-1:0]      bcd_x;
    logic [STEP_W-1:0]     step, step_n;
    logic [DIGITS*7-1:0]   seg, seg_n;
    logic                  ovf;

    assign wr    = bus.io_we && (word == 6'(16 + k));
    assign bcd_x = PAD_W'(bcd);

    always_ff @(posedge clk) begin
      if (reset) begin
        out_port[k*32 +: 32] <= '0;
      end else if (wr) begin
        out_port[k*32 +: 32] <= bus.io_wdata;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        shift <= '0;
        bcd   <= '0;
        step  <= '0;
        seg   <= {DIGITS{SEG_ZERO}};
      end else begin
        state <= state_n;
        shift <= shift_n;
        bcd   <= bcd_n;
        step  <= step_n;
        seg   <= seg_n;
      end
    end

    always_comb begin
      state_n = state;
      shift_n = shift;
      bcd_n   = bcd;
      step_n  = step;
      seg_n   = seg;
      adj     = bcd;
      ovf     = 1'b0;
      for (int n = 0; n < NIB; n++) begin
        if (bcd[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
      for (int n = DIGITS; n < NIB; n++) begin
        if (bcd_x[4*n +: 4] != 4'd0) ovf = 1'b1;
      end
      case (state)
        SHIFT: begin
          {bcd_n, shift_n} = {adj, shift} << 1;
          step_n = step + 1'b1;
          if (step_n == STEP_W'(CONV_W)) state_n = LOAD;
        end
        LOAD: begin
          for (int d = 0; d < DIGITS; d++) begin
            seg_n[d*7 +: 7] = ovf ? SEG_DASH : seg7(bcd_x[4*d +: 4]);
          end
          state_n = IDLE;
        end
        default: ;
      endcase
      // A write restarts the conversion and suppresses any pending load.
      if (wr) begin
        state_n = SHIFT;
        shift_n = bus.io_wdata[CONV_W-1:0];
        bcd_n   = '0;
        step_n  = '0;
        seg_n   = seg;
      end
    end

    assign hex[k*DIGITS*7 +: DIGITS*7] = seg;
    assign busy[k] = (state != IDLE);
  end

  always_comb begin
    bus.io_rdata = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (word == 6'(i)) bus.io_rdata = 32'(stable_all[i*IN_W +: IN_W]);
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (word == 6'(16 + i)) bus.io_rdata = out_port[i*32 +: 32];
    end
    if (word == 6'd31) bus.io_rdata = 32'(busy);
  end

endmodule

// File: tb/tb_sc_io_bus.sv
// Bench for sc_io_bus: arithmetic reference model checked every cycle, plus
// directed literal expectations for reset, debounce, conversion and abort.
module tb_sc_io_bus;
  localparam int N_IN = 2, IN_W = 5, N_OUT = 3, DIGITS = 2, CONV_W = 7, DBNC = 4;
  localparam int SW_W = N_IN * IN_W;
  localparam logic [6:0] S0 = 7'b1000000, DASH = 7'b0111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [SW_W-1:0] sw = '0;
  logic [N_OUT*32-1:0] out_port;
  logic [N_OUT*DIGITS*7-1:0] hex;
  logic [N_OUT-1:0] busy;

  sc_io_bus_if bif();

  sc_io_bus #(.N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .DIGITS(DIGITS),
              .CONV_W(CONV_W), .DBNC(DBNC)) dut (
    .clk(clk), .reset(reset), .bus(bif.slave), .sw(sw),
    .out_port(out_port), .hex(hex), .busy(busy));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [DIGITS*7-1:0] show(input int v);
    logic [DIGITS*7-1:0] r;
    int p;
    r = '0;
    p = 1;
    if (v >= 10 ** DIGITS) return {DIGITS{DASH}};
    for (int d = 0; d < DIGITS; d++) begin
      r[d*7 +: 7] = seg_of((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: a conversion is a delay of CONV_W+1 edges, then the
  // decimal value of the low CONV_W bits; an input is accepted once DBNC+1
  // consecutive samples agree and differ from the current value.
  logic [31:0]         m_out [N_OUT];
  int                  m_val [N_OUT];
  int                  m_rem [N_OUT];
  logic [DIGITS*7-1:0] m_hex [N_OUT];
  logic [IN_W-1:0]     m_stable [N_IN];
  logic [IN_W-1:0]     hist [N_IN][DBNC+1];
  bit                  m_valid = 1'b0;

  function automatic logic [N_OUT-1:0] m_busy();
    logic [N_OUT-1:0] b;
    for (int k = 0; k < N_OUT; k++) b[k] = (m_rem[k] > 0);
    return b;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    int w;
    w = int'(a[7:2]);
    if (w < N_IN) return 32'(m_stable[w]);
    if (w >= 16 && w < 16 + N_OUT) return m_out[w-16];
    if (w == 31) return 32'(m_busy());
    return 32'd0;
  endfunction

  always @(posedge clk) begin : model
    int w;
    bit same;
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) begin
        m_out[k] = '0; m_val[k] = 0; m_rem[k] = 0; m_hex[k] = {DIGITS{S0}};
      end
      for (int c = 0; c < N_IN; c++) begin
        m_stable[c] = '0;
        for (int i = 0; i <= DBNC; i++) hist[c][i] = '0;
      end
      m_valid = 1'b1;
    end else begin
      w = int'(bif.io_addr[7:2]);
      for (int k = 0; k < N_OUT; k++) begin
        if (bif.io_we && w == 16 + k) begin
          m_out[k] = bif.io_wdata;
          m_val[k] = int'(bif.io_wdata & 32'((1 << CONV_W) - 1));
          m_rem[k] = CONV_W + 1;
        end else if (m_rem[k] > 0) begin
          m_rem[k]--;
          if (m_rem[k] == 0) m_hex[k] = show(m_val[k]);
        end
      end
      for (int c = 0; c < N_IN; c++) begin
        same = 1'b1;
        for (int i = 1; i <= DBNC; i++) if (hist[c][i] != hist[c][0]) same = 1'b0;
        if (same && hist[c][0] != m_stable[c]) m_stable[c] = hist[c][0];
        for (int i = DBNC; i > 0; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = sw[c*IN_W +: IN_W];
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [N_OUT*32-1:0] eo;
    logic [N_OUT*DIGITS*7-1:0] eh;
    if (m_valid) begin
      for (int k = 0; k < N_OUT; k++) begin
        eo[k*32 +: 32] = m_out[k];
        eh[k*DIGITS*7 +: DIGITS*7] = m_hex[k];
      end
      chk("model_out_port", 128'(out_port), 128'(eo));
      chk("model_hex", 128'(hex), 128'(eh));
      chk("model_busy", 128'(busy), 128'(m_busy()));
      chk("model_rdata", 128'(bif.io_rdata), 128'(exp_rd(bif.io_addr)));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bif.io_addr = a; bif.io_wdata = d; bif.io_we = 1'b1;
    step(1);
    bif.io_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    bif.io_addr = a;
    #1;
    chk(name, 128'(bif.io_rdata), 128'(exp));
  endtask

  initial begin : stim
    bit saw57;
    bif.io_addr = '0; bif.io_we = 1'b0; bif.io_wdata = '0;
    reset = 1'b1;
    step(2);
    chk("rst_out_port", 128'(out_port), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_hex", 128'(hex), 128'({6{S0}}));
    rd_chk("rst_rd00", 8'h00, 32'd0);
    rd_chk("rst_rd40", 8'h40, 32'd0);
    rd_chk("rst_rd7c", 8'h7C, 32'd0);

    // Debounce: 10101 held on channel 0
    reset = 1'b0;
    sw[4:0] = 5'b10101;
    step(5);
    rd_chk("dbnc_e0p4", 8'h00, 32'd0);
    step(1);
    rd_chk("dbnc_e0p5", 8'h00, 32'd21);
    // 3- and 4-cycle pulses on channel 1 are rejected
    sw[9:5] = 5'b11111; step(3); sw[9:5] = '0; step(10);
    rd_chk("pulse3", 8'h04, 32'd0);
    sw[9:5] = 5'b11111; step(4); sw[9:5] = '0; step(10);
    rd_chk("pulse4", 8'h04, 32'd0);
    // 5-cycle pulse is just long enough
    sw[9:5] = 5'b11111; step(5); sw[9:5] = '0; step(1);
    rd_chk("pulse5", 8'h04, 32'd31);
    step(8);
    rd_chk("pulse5_back", 8'h04, 32'd0);

    // Convert 42 on port 0
    wr(8'h40, 32'd42);
    chk("conv_out0", 128'(out_port[31:0]), 128'(42));
    rd_chk("conv_busy_t1", 8'h7C, 32'd1);
    step(7);
    chk("conv_busy_t8", 128'(busy[0]), 128'(1));
    chk("conv_hex_held", 128'(hex[13:0]), 128'({S0, S0}));
    step(1);
    chk("conv_busy_done", 128'(busy[0]), 128'(0));
    chk("conv_tens", 128'(hex[13:7]), 128'(7'b0011001));
    chk("conv_ones", 128'(hex[6:0]), 128'(7'b0100100));

    // Overflow and truncation
    wr(8'h48, 32'd123);
    step(8);
    chk("ovf_dash", 128'(hex[41:28]), 128'({DASH, DASH}));
    wr(8'h44, 32'd200);
    step(8);
    chk("trunc_72", 128'(hex[27:14]), 128'({7'b1111000, 7'b0100100}));
    rd_chk("trunc_rd", 8'h44, 32'd200);

    // Back-to-back writes to different ports
    wr(8'h40, 32'd5);
    wr(8'h44, 32'd99);
    step(7);
    chk("b2b_busy", 128'(busy), 128'(3'b010));
    chk("b2b_p0", 128'(hex[13:0]), 128'({S0, 7'b0010010}));
    step(1);
    chk("b2b_p1", 128'(hex[27:14]), 128'({7'b0010000, 7'b0010000}));

    // Restart: 57 at T, 9 at T+2
    wr(8'h40, 32'd57);
    step(1);
    wr(8'h40, 32'd9);
    saw57 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("restart_busy_t10", 128'(busy[0]), 128'(1));
      step(1);
      if (hex[13:0] == {7'b0010010, 7'b1111000}) saw57 = 1'b1;
    end
    chk("restart_no57", 128'(saw57), 128'(0));
    chk("restart_09", 128'(hex[13:0]), 128'({S0, 7'b0010000}));

    // Unmapped write
    wr(8'h60, 32'hDEAD_BEEF);
    chk("unmap_out", 128'(out_port), 128'({32'd123, 32'd99, 32'd9}));
    chk("unmap_busy", 128'(busy), 128'(0));
    rd_chk("unmap_rd", 8'h60, 32'd0);
    wr(8'h00, 32'h1F);
    rd_chk("ro_input", 8'h00, 32'd21);

    // Random traffic cross-checked by the model
    for (int i = 0; i < 150; i++) begin
      bif.io_addr = 8'($urandom);
      if ($urandom_range(0, 1) == 1) bif.io_addr = 8'(8'h40 + 4 * $urandom_range(0, 2));
      bif.io_we = ($urandom_range(0, 2) == 0);
      bif.io_wdata = $urandom;
      if ($urandom_range(0, 5) == 0) sw = SW_W'($urandom);
      step(1);
    end
    bif.io_we = 1'b0;
    step(12);

    // Reset aborts a running conversion
    wr(8'h40, 32'd77);
    step(2);
    reset = 1'b1;
    step(1);
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_hex", 128'(hex), 128'({6{S0}}));
    chk("abort_out", 128'(out_port), 128'(0));
    reset = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
